// File: rtl/ldpc_decode_sequencer.sv
// ldpc_decode_sequencer
// Runs one stochastic hard-decision LDPC decode: clears the counter bank,
// warms the decoder up, then watches the hard decisions and parity result
// until they stay stable long enough, the cycle budget runs out, or the
// host aborts. The final word and a converged flag are latched at the end.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; previous result held
// S_CLR   | init_out high for INITCYC cycles, decoder stopped
// S_WARM  | decoder running, no convergence evaluation
// S_CHECK | decoder running, stability and budget evaluated every cycle
// S_FIN   | one-cycle done pulse, busy already low
module ldpc_decode_sequencer #(
  parameter int NBITS   = 8,
  parameter int MAXCYC  = 1000,
  parameter int WARMUP  = 16,
  parameter int STABLE  = 4,
  parameter int INITCYC = 2,
  parameter int CW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NBITS-1:0] dec_in,
  input  logic             synd_ok,
  output logic             init_out,
  output logic             run,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic [NBITS-1:0] dec_out,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (INITCYC > 1) ? $clog2(INITCYC) : 1;
  localparam int SW = $clog2(STABLE + 1);

  localparam logic [IW-1:0] INIT_LAST = IW'(INITCYC - 1);
  localparam logic [SW-1:0] STAB_TGT  = SW'(STABLE);
  localparam logic [CW-1:0] WARM_END  = CW'(WARMUP);
  localparam logic [CW-1:0] CYC_MAX   = CW'(MAXCYC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_WARM  = 3'd2,
    S_CHECK = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    init_cnt;
  logic [SW-1:0]    stab_cnt;
  logic [NBITS-1:0] hist;
  logic             hist_vld;

  logic [CW-1:0]    cyc_inc;
  logic             match;
  logic [SW-1:0]    stab_inc;
  logic             conv_hit;
  logic             budget_hit;

  // cycle count after this cycle, stability count after this cycle, and exit conditions
  always_comb begin
    cyc_inc    = (cycles == CYC_MAX) ? cycles : cycles + CW'(1);
    match      = hist_vld && synd_ok && (dec_in == hist);
    stab_inc   = match ? stab_cnt + SW'(1) : '0;
    conv_hit   = (state == S_CHECK) && (stab_inc == STAB_TGT);
    budget_hit = (state == S_CHECK) && (cyc_inc == CYC_MAX);
  end

  // next-state decode; abort and convergence both beat budget exhaustion
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLR;
      S_CLR:   if (init_cnt == INIT_LAST) state_nxt = S_WARM;
      S_WARM: begin
        if (abort)                   state_nxt = S_FIN;
        else if (cyc_inc == WARM_END) state_nxt = S_CHECK;
      end
      S_CHECK: if (abort || conv_hit || budget_hit) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // registered outputs, counters, history and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_out  <= 1'b0;
      run       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      dec_out   <= '0;
      cycles    <= '0;
      init_cnt  <= '0;
      stab_cnt  <= '0;
      hist      <= '0;
      hist_vld  <= 1'b0;
    end else begin
      init_out <= (state_nxt == S_CLR);
      run      <= (state_nxt == S_WARM) || (state_nxt == S_CHECK);
      busy     <= (state_nxt == S_CLR) || (state_nxt == S_WARM) || (state_nxt == S_CHECK);
      done     <= (state_nxt == S_FIN);
      init_cnt <= (state == S_CLR) ? init_cnt + IW'(1) : '0;

      if (state_nxt == S_CLR) begin
        converged <= 1'b0;
        cycles    <= '0;
        stab_cnt  <= '0;
        hist      <= '0;
        hist_vld  <= 1'b0;
      end else if ((state == S_WARM) || (state == S_CHECK)) begin
        cycles <= cyc_inc;
        if (state == S_CHECK) begin
          hist     <= dec_in;
          hist_vld <= 1'b1;
          stab_cnt <= stab_inc;
        end
        if (state_nxt == S_FIN) begin
          converged <= conv_hit && !abort;
          dec_out   <= dec_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_ldpc_decode_sequencer.sv
// tb_ldpc_decode_sequencer
// Drives per-cycle stimulus tables into the sequencer and compares its
// outputs against a cycle-walk reference built from the decode rules.
module tb_ldpc_decode_sequencer;

  localparam int NBITS   = 8;
  localparam int MAXCYC  = 1000;
  localparam int WARMUP  = 16;
  localparam int STABLE  = 4;
  localparam int INITCYC = 2;
  localparam int CW      = 16;
  localparam int MAXC1   = 24;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             synd_ok = 1'b0;
  logic [NBITS-1:0] dec_in = '0;

  logic             d0_init, d0_run, d0_busy, d0_done, d0_conv;
  logic [NBITS-1:0] d0_dout;
  logic [CW-1:0]    d0_cyc;
  logic             d1_init, d1_run, d1_busy, d1_done, d1_conv;
  logic [NBITS-1:0] d1_dout;
  logic [CW-1:0]    d1_cyc;

  logic             which = 1'b0;
  logic             o_init, o_run, o_busy, o_done, o_conv;
  logic [NBITS-1:0] o_dout;
  logic [CW-1:0]    o_cyc;

  int n_cmp = 0;
  int n_bad = 0;
  int lat, cyc;
  bit saw;

  logic [NBITS-1:0] d_seq [0:MAXCYC];
  bit               s_seq [0:MAXCYC];
  bit               a_seq [0:MAXCYC];

  ldpc_decode_sequencer #(.NBITS(NBITS), .MAXCYC(MAXCYC), .WARMUP(WARMUP),
    .STABLE(STABLE), .INITCYC(INITCYC), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dec_in(dec_in),
    .synd_ok(synd_ok), .init_out(d0_init), .run(d0_run), .busy(d0_busy),
    .done(d0_done), .converged(d0_conv), .dec_out(d0_dout), .cycles(d0_cyc));

  ldpc_decode_sequencer #(.NBITS(NBITS), .MAXCYC(MAXC1), .WARMUP(WARMUP),
    .STABLE(STABLE), .INITCYC(INITCYC), .CW(CW)) dut_short (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dec_in(dec_in),
    .synd_ok(synd_ok), .init_out(d1_init), .run(d1_run), .busy(d1_busy),
    .done(d1_done), .converged(d1_conv), .dec_out(d1_dout), .cycles(d1_cyc));

  assign o_init = which ? d1_init : d0_init;
  assign o_run  = which ? d1_run  : d0_run;
  assign o_busy = which ? d1_busy : d0_busy;
  assign o_done = which ? d1_done : d0_done;
  assign o_conv = which ? d1_conv : d0_conv;
  assign o_dout = which ? d1_dout : d0_dout;
  assign o_cyc  = which ? d1_cyc  : d0_cyc;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: walk the running cycles k=1.. and apply the decode rules.
  function automatic void model(input int maxcyc, output int kend, output bit conv);
    int st;
    st = 0;
    kend = maxcyc;
    conv = 1'b0;
    for (int k = 1; k <= maxcyc; k++) begin
      if (k > WARMUP) begin
        if (k > WARMUP + 1 && s_seq[k] && d_seq[k] == d_seq[k-1]) st++;
        else st = 0;
      end
      if (a_seq[k])    begin kend = k; conv = 1'b0; return; end
      if (st == STABLE) begin kend = k; conv = 1'b1; return; end
      if (k == maxcyc) begin kend = k; conv = 1'b0; return; end
    end
  endfunction

  task automatic gen_const(input logic [NBITS-1:0] v, input bit s);
    for (int k = 0; k <= MAXCYC; k++) begin
      d_seq[k] = v; s_seq[k] = s; a_seq[k] = 1'b0;
    end
  endtask

  task automatic gen_random();
    logic [NBITS-1:0] v;
    int ab, idx;
    v  = NBITS'($urandom);
    ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
    for (int k = 0; k <= MAXCYC; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, NBITS - 1));
        v[idx] = ~v[idx];
      end
      d_seq[k] = v;
      s_seq[k] = ($urandom_range(0, 7) != 0);
      a_seq[k] = (k == ab);
    end
  endtask

  task automatic run_decode(input int maxcyc, input bit start_noise, input bit clr_abort,
                            input bit hold_start, output int lat_obs, output int cyc_obs);
    int kend, last, k;
    bit conv;
    model(maxcyc, kend, conv);
    last    = INITCYC + kend;
    lat_obs = -1;
    cyc_obs = -1;
    start   = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n <= last; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      check_eq("init_out", 32'(o_init), 32'(n < INITCYC));
      check_eq("run",      32'(o_run),  32'(n >= INITCYC && n < last));
      check_eq("busy",     32'(o_busy), 32'(n < last));
      check_eq("done",     32'(o_done), 32'(n == last));
      if (o_done && lat_obs < 0) lat_obs = n + 1;
      if (n < INITCYC) begin
        check_eq("clr_converged", 32'(o_conv), 32'd0);
        check_eq("clr_cycles",    32'(o_cyc),  32'd0);
        abort   = clr_abort;
        dec_in  = NBITS'($urandom);
        synd_ok = 1'($urandom);
      end else if (n < last) begin
        k       = n - INITCYC + 1;
        dec_in  = d_seq[k];
        synd_ok = s_seq[k];
        abort   = a_seq[k];
      end else begin
        check_eq("converged", 32'(o_conv), 32'(conv));
        check_eq("dec_out",   32'(o_dout), 32'(d_seq[kend]));
        check_eq("cycles",    32'(o_cyc),  32'(kend));
        cyc_obs = int'(o_cyc);
        abort   = 1'($urandom);
        dec_in  = NBITS'($urandom);
        synd_ok = 1'($urandom);
      end
      start = (n == last) ? hold_start : (start_noise ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    @(posedge clk); #1;
    check_eq("idle_busy", 32'(o_busy), 32'd0);
    check_eq("idle_done", 32'(o_done), 32'd0);
    start = hold_start;
    abort = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_init"}, 32'(o_init), 32'd0);
    check_eq({tag, "_run"},  32'(o_run),  32'd0);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_done"}, 32'(o_done), 32'd0);
    check_eq({tag, "_conv"}, 32'(o_conv), 32'd0);
    check_eq({tag, "_dout"}, 32'(o_dout), 32'd0);
    check_eq({tag, "_cyc"},  32'(o_cyc),  32'd0);
  endtask

  // hard stop if something never returns
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // stimulus sequence
  initial begin
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // constant word, parity satisfied: minimum latency
    gen_const(8'hA5, 1'b1);
    run_decode(MAXCYC, 1'b0, 1'b0, 1'b0, lat, cyc);
    check_eq("imm_latency", 32'(lat), 32'd24);
    check_eq("imm_cycles",  32'(cyc), 32'd21);

    // one bit flips after three stable cycles, then holds
    gen_const(8'hA5, 1'b1);
    for (int k = 21; k <= MAXCYC; k++) d_seq[k] = 8'hA4;
    run_decode(MAXCYC, 1'b0, 1'b0, 1'b0, lat, cyc);
    check_eq("brk_latency", 32'(lat), 32'd28);
    check_eq("brk_cycles",  32'(cyc), 32'd25);

    // abort in CHECK at cycle 50
    gen_const(8'h3C, 1'b0);
    a_seq[50] = 1'b1;
    run_decode(MAXCYC, 1'b0, 1'b0, 1'b0, lat, cyc);
    check_eq("abort_cycles", 32'(cyc), 32'd50);

    // abort held during CLR is ignored; start pulses while busy ignored
    gen_const(8'hC3, 1'b1);
    run_decode(MAXCYC, 1'b1, 1'b1, 1'b1, lat, cyc);
    check_eq("clrabort_cycles", 32'(cyc), 32'd21);

    // reset in the middle of WARM
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    dec_in  = 8'h77;
    synd_ok = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("pre_rst_run", 32'(o_run), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_done || o_busy) saw = 1'b1;
    end
    check_eq("midrst_quiet", 32'(saw), 32'd0);

    // budget exhaustion
    gen_const(8'h00, 1'b0);
    for (int k = 0; k <= MAXCYC; k++) d_seq[k] = NBITS'($urandom);
    run_decode(MAXCYC, 1'b0, 1'b0, 1'b0, lat, cyc);
    check_eq("budget_cycles", 32'(cyc), 32'd1000);

    // randomized decodes
    for (int i = 0; i < 15; i++) begin
      gen_random();
      run_decode(MAXCYC, 1'($urandom), 1'($urandom), 1'($urandom), lat, cyc);
    end

    // convergence on the very last budget cycle (short-budget instance)
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b0;
    #2;
    rst_n = 1'b1;
    which = 1'b1;
    gen_const(8'h5A, 1'b1);
    for (int k = 20; k <= MAXCYC; k++) d_seq[k] = 8'h5B;
    run_decode(MAXC1, 1'b0, 1'b0, 1'b0, lat, cyc);
    check_eq("edge_cycles",  32'(cyc), 32'd24);
    check_eq("edge_latency", 32'(lat), 32'd27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ldpc_decode_sequencer.md
Name: ldpc_decode_sequencer

Overview:
Sequences one stochastic LDPC hard-decision decode over a bank of triple-counter majority hard-decision units. It clears the counters with a synchronous INIT pulse, then runs the stochastic decoder for a warm-up period. It monitors the hard decisions and the parity-check result for convergence and terminates on convergence or on a cycle budget. At the end it latches the decoded word and signals DONE to the frame-level host.

Parameters:
NBITS, 8, number of variable nodes (hard-decision bits)
MAXCYC, 1000, maximum decode cycles after INIT, including warm-up
WARMUP, 16, cycles after INIT before convergence checks start; must be less than MAXCYC
STABLE, 4, consecutive cycles in which SYND_OK=1 and DEC_IN is unchanged, required to declare convergence
INITCYC, 2, cycles INIT_OUT is held high
CW, 16, width of cycle counter and CYCLES output; 2^CW must exceed MAXCYC

Ports:
CLK  in  1  system clock, rising edge
RSTn  in  1  asynchronous active-low reset
START  in  1  request a decode; sampled only in IDLE
ABORT  in  1  terminate the current decode as non-converged
DEC_IN  in  NBITS  hard decisions from the counter bank (BitOUT of each unit)
SYND_OK  in  1  high when all parity checks are satisfied by DEC_IN
INIT_OUT  out  1  drives INIT of every counter unit
RUN  out  1  enables the stochastic bit generators and node updates
BUSY  out  1  high from START acceptance until DONE
DONE  out  1  one-cycle pulse at end of decode
CONVERGED  out  1  result flag, valid from DONE until next START
DEC_OUT  out  NBITS  latched decoded word
CYCLES  out  CW  decode cycles used; saturates at MAXCYC

Behaviour:
- Reset (RSTn=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: INIT_OUT, RUN, BUSY, DONE, CONVERGED, DEC_OUT, CYCLES.
  - All internal counters and the DEC_IN history register are cleared.
- Reset asserted mid-decode aborts immediately; DONE is not generated.
- States: IDLE, CLR, WARM, CHECK, FIN. Every transition occurs on the rising CLK edge.
- IDLE:
  - START=1 moves to CLR. BUSY=1 from the next cycle.
  - CONVERGED and DEC_OUT keep the previous result until CLR.
- CLR:
  - INIT_OUT=1 for exactly INITCYC cycles; RUN=0.
  - CONVERGED, CYCLES, the stable counter and the history register are cleared.
  - Then moves to WARM.
- WARM:
  - RUN=1. The cycle counter increments every cycle.
  - After WARMUP cycles moves to CHECK.
  - No convergence evaluation during WARM.
- CHECK:
  - RUN=1. The cycle counter increments every cycle; the history register captures DEC_IN every cycle.
  - The stable counter increments when SYND_OK=1 and DEC_IN equals the previous cycle's DEC_IN. Otherwise it resets to 0.
  - The first CHECK cycle has no valid history and counts as a mismatch.
  - Convergence: the stable counter reaches STABLE. Set CONVERGED=1, latch DEC_IN into DEC_OUT, and move to FIN.
  - Budget exhaustion: cycle counter equals MAXCYC with no convergence. Set CONVERGED=0, latch DEC_IN, and move to FIN.
  - If convergence and budget exhaustion occur in the same cycle, convergence wins.
- ABORT:
  - ABORT=1 in WARM or CHECK moves to FIN with CONVERGED=0 and latches DEC_IN.
  - ABORT=1 in CLR or FIN is ignored. ABORT=1 in IDLE has no effect.
- FIN:
  - RUN=0, DONE=1 for one cycle, BUSY drops to 0 in the same cycle, then returns to IDLE.
  - CYCLES holds the WARM+CHECK cycle count.
- START while BUSY=1 is ignored (no queueing).
- START held high continuously re-launches on the cycle after FIN.
- Latency: minimum from START to DONE is 1 + INITCYC + WARMUP + STABLE + 1 cycles (the +1 inside accounts for the invalid first CHECK cycle).
- All outputs are registered. DEC_IN and SYND_OK are assumed synchronous to CLK.

Test Plan:
- Reset mid-decode: start a decode, assert RSTn=0 during WARM -> all outputs are 0 asynchronously; no DONE after release; the next START runs a normal decode.
- Immediate convergence: defaults, DEC_IN=8'hA5 constant, SYND_OK=1, START pulse -> INIT_OUT high for 2 cycles; DONE exactly 1+2+16+5 = 24 cycles after START; CONVERGED=1, DEC_OUT=8'hA5, CYCLES=21.
- Stability break: in CHECK, toggle one DEC_IN bit after 3 stable cycles, then hold -> stable count restarts; DONE delayed accordingly; CONVERGED=1 with the final word.
- Budget exhaustion: SYND_OK=0 throughout -> DONE after CYCLES=1000; CONVERGED=0; DEC_OUT equals DEC_IN at the last cycle.
- ABORT and collisions:
  - ABORT in CHECK at cycle 50 -> FIN next cycle, CONVERGED=0, CYCLES=50.
  - ABORT during CLR -> ignored.
  - START pulses while BUSY -> ignored.
- Edge collision: MAXCYC=24, stable count reaches STABLE on cycle 24 -> CONVERGED=1.
